// File: rtl/operand_loader_pkg.sv
// ============================================================================
// Module   : operand_loader_pkg
// Brief    : State encodings and default data width for operand_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_loader_pkg;

  localparam int unsigned c_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    SHOW_A = 2'b10,
    SHOW_B = 2'b11
  } state_e;

endpackage

`default_nettype wire

// File: rtl/operand_loader.sv
// ============================================================================
// Module   : operand_loader
// Brief    : Loads two operands, then presents them to a downstream 2:1 mux.
//            Define OPLOAD_CNT_EN to add the PAIR_CNT completed-pair counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int unsigned WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             S,
  output logic             OUT_VALID,
  input  logic             OUT_ACK
`ifdef OPLOAD_CNT_EN
  ,
  output logic [7:0]       PAIR_CNT
`endif
);

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_s;
  logic             r_out_valid;
  logic             r_din_ready;
  logic             w_pair_done;

  // Outputs are updated together with the state so they never depend on inputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= WAIT_A;
      r_a         <= '0;
      r_b         <= '0;
      r_s         <= 1'b0;
      r_out_valid <= 1'b0;
      r_din_ready <= 1'b1;
    end else begin
      case (r_state)
        WAIT_A: begin
          if (DIN_VALID) begin
            r_a     <= DIN;
            r_state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (DIN_VALID) begin
            r_b         <= DIN;
            r_state     <= SHOW_A;
            r_out_valid <= 1'b1;
            r_din_ready <= 1'b0;
          end
        end
        SHOW_A: begin
          if (OUT_ACK) begin
            r_state <= SHOW_B;
            r_s     <= 1'b1;
          end
        end
        SHOW_B: begin
          if (OUT_ACK) begin
            r_state     <= WAIT_A;
            r_s         <= 1'b0;
            r_out_valid <= 1'b0;
            r_din_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= WAIT_A;
          r_s         <= 1'b0;
          r_out_valid <= 1'b0;
          r_din_ready <= 1'b1;
        end
      endcase
    end
  end

  assign w_pair_done = (r_state == SHOW_B) && OUT_ACK;

`ifdef OPLOAD_CNT_EN
  logic [7:0] r_pair_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pair_cnt <= 8'd0;
    end else if (w_pair_done) begin
      r_pair_cnt <= r_pair_cnt + 8'd1;
    end
  end

  assign PAIR_CNT = r_pair_cnt;
`else
  logic w_unused;
  assign w_unused = w_pair_done;
`endif

  assign DIN_READY = r_din_ready;
  assign A         = r_a;
  assign B         = r_b;
  assign S         = r_s;
  assign OUT_VALID = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_operand_loader.sv
// ============================================================================
// Module   : tb_operand_loader
// Brief    : Self-checking bench for operand_loader (randomized + directed).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_loader;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] DIN = 8'h00;
  logic       DIN_VALID = 1'b0;
  logic       DIN_READY;
  logic [7:0] A;
  logic [7:0] B;
  logic       S;
  logic       OUT_VALID;
  logic       OUT_ACK = 1'b0;
`ifdef OPLOAD_CNT_EN
  logic [7:0] PAIR_CNT;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference: count of operands held and acks received for the current pair.
  int         m_loaded;
  int         m_acks;
  logic [7:0] m_a;
  logic [7:0] m_b;
  int         m_pairs;

  always #5 CLK = ~CLK;

  operand_loader #(.WIDTH(8)) u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_READY (DIN_READY),
    .A         (A),
    .B         (B),
    .S         (S),
    .OUT_VALID (OUT_VALID),
    .OUT_ACK   (OUT_ACK)
`ifdef OPLOAD_CNT_EN
    ,
    .PAIR_CNT  (PAIR_CNT)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_loaded = 0;
    m_acks   = 0;
    m_a      = 8'h00;
    m_b      = 8'h00;
    m_pairs  = 0;
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] d, input logic k);
    if (m_loaded < 2) begin
      if (v) begin
        if (m_loaded == 0) m_a = d;
        else               m_b = d;
        m_loaded++;
      end
    end else if (k) begin
      m_acks++;
      if (m_acks == 2) begin
        m_loaded = 0;
        m_acks   = 0;
        m_pairs  = (m_pairs + 1) % 256;
      end
    end
  endfunction

  task automatic compare_all(input string ph);
    check({ph, ":A"}, {24'd0, A}, {24'd0, m_a});
    check({ph, ":B"}, {24'd0, B}, {24'd0, m_b});
    check({ph, ":S"}, {31'd0, S}, {31'd0, (m_loaded == 2) && (m_acks == 1)});
    check({ph, ":OUT_VALID"}, {31'd0, OUT_VALID}, {31'd0, m_loaded == 2});
    check({ph, ":DIN_READY"}, {31'd0, DIN_READY}, {31'd0, m_loaded < 2});
`ifdef OPLOAD_CNT_EN
    check({ph, ":PAIR_CNT"}, {24'd0, PAIR_CNT}, m_pairs);
`endif
  endtask

  task automatic cycle(input string ph, input logic v, input logic [7:0] d, input logic k);
    DIN_VALID = v;
    DIN       = d;
    OUT_ACK   = k;
    @(posedge CLK);
    model_step(v, d, k);
    #1;
    compare_all(ph);
  endtask

  // Async reset asserted away from any edge; held over one edge with DIN_VALID high.
  task automatic async_reset(input string ph);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    compare_all({ph, "_imm"});
    DIN_VALID = 1'b1;
    DIN       = 8'h55;
    OUT_ACK   = 1'b1;
    @(posedge CLK);
    #1;
    compare_all({ph, "_hold"});
    #2;
    RST = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    RST = 1'b1;
    #1;
    compare_all("reset_imm");
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    compare_all("reset_rel");

    // Basic pair.
    cycle("basic", 1'b1, 8'h3C, 1'b0);
    cycle("basic", 1'b1, 8'hA5, 1'b0);
    check("basic_A", {24'd0, A}, 32'h3C);
    check("basic_B", {24'd0, B}, 32'hA5);
    check("basic_S0", {31'd0, S}, 32'd0);
    cycle("basic", 1'b0, 8'h00, 1'b1);
    check("basic_S1", {31'd0, S}, 32'd1);
    cycle("basic", 1'b0, 8'h00, 1'b1);
    check("basic_done", {30'd0, OUT_VALID, DIN_READY}, 32'd1);

    // Stall between operands with an ignored ack in WAIT_B.
    cycle("stall", 1'b1, 8'h11, 1'b0);
    for (int i = 0; i < 5; i++) cycle("stall", 1'b0, 8'hEE, (i == 2));
    check("stall_A", {24'd0, A}, 32'h11);
    cycle("stall", 1'b1, 8'h22, 1'b0);

    // DIN offered while showing must be ignored.
    cycle("ignore", 1'b1, 8'hFF, 1'b0);
    cycle("ignore", 1'b1, 8'hFF, 1'b1);
    cycle("ignore", 1'b1, 8'hFF, 1'b1);
    cycle("ignore", 1'b1, 8'h6B, 1'b0);
    check("ignore_A", {24'd0, A}, 32'h6B);
    cycle("ignore", 1'b1, 8'h7C, 1'b1);
    cycle("ignore", 1'b0, 8'h00, 1'b1);
    cycle("ignore", 1'b0, 8'h00, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    // Reset in SHOW_B discards the pair without counting it.
    async_reset("pre_show_b");
    cycle("midrst", 1'b1, 8'h0F, 1'b0);
    cycle("midrst", 1'b1, 8'hF0, 1'b0);
    cycle("midrst", 1'b0, 8'h00, 1'b1);
    check("midrst_S", {31'd0, S}, 32'd1);
    async_reset("show_b");
    cycle("midrst_after", 1'b1, 8'h99, 1'b0);

    // Back-to-back pairs with ack held high: wrap of the pair counter.
    async_reset("pre_wrap");
    for (int p = 0; p < 257; p++) begin
      cycle("wrap", 1'b1, 8'($urandom), 1'b1);
      cycle("wrap", 1'b1, 8'($urandom), 1'b1);
      cycle("wrap", 1'b1, 8'h00, 1'b1);
      cycle("wrap", 1'b1, 8'h00, 1'b1);
`ifdef OPLOAD_CNT_EN
      if (p == 255) check("wrap_256", {24'd0, PAIR_CNT}, 32'h00);
      if (p == 256) check("wrap_257", {24'd0, PAIR_CNT}, 32'h01);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
